// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct constants, the bubble word and instruction field helpers.
package mips_pkg;

  // Opcode and funct values; names pair an opcode with the funct sharing its encoding.
  localparam logic [5:0] ADDI_JR = 6'b001000;
  localparam logic [5:0] BLTZ    = 6'b000001;
  localparam logic [5:0] J       = 6'b000010;
  localparam logic [5:0] LW_SUBU = 6'b100011;
  localparam logic [5:0] NOR     = 6'b100111;
  localparam logic [5:0] SLTU_SW = 6'b101011;

  localparam logic [31:0] BUBBLE_WORD = 32'h0000_0000;

  function automatic logic [5:0] get_op(input logic [31:0] inst);
    return inst[31:26];
  endfunction

  function automatic logic [4:0] get_rs(input logic [31:0] inst);
    return inst[25:21];
  endfunction

  function automatic logic [4:0] get_rt(input logic [31:0] inst);
    return inst[20:16];
  endfunction

  function automatic logic [4:0] get_rd(input logic [31:0] inst);
    return inst[15:11];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between the ID and EX instruction words.
module hazard_detect
  import mips_pkg::*;
(
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  input  logic [31:0] ex_inst,
  input  logic        ex_valid,
  output logic        load_use
);

  logic uses_rs;
  logic uses_rt;
  logic ex_is_load;
  logic rs_match;
  logic rt_match;

  // A jump carries no rs; only R-type and stores read rt as a source.
  always_comb begin
    uses_rs    = id_valid && (get_op(id_inst) != J);
    uses_rt    = id_valid && ((get_op(id_inst) == 6'b000000) || (get_op(id_inst) == SLTU_SW));
    ex_is_load = ex_valid && (get_op(ex_inst) == LW_SUBU) && (get_rt(ex_inst) != 5'd0);
    rs_match   = uses_rs && (get_rs(id_inst) == get_rt(ex_inst));
    rt_match   = uses_rt && (get_rt(id_inst) == get_rt(ex_inst));
    load_use   = ex_is_load && (rs_match || rt_match);
  end

endmodule

// File: rtl/inst_pipe_tracker.sv
// ID/EX/MEM instruction-word pipeline with load-use stalls, redirect flushes and a bubble counter.
module inst_pipe_tracker
  import mips_pkg::*;
#(
  parameter logic [31:0] BUBBLE = BUBBLE_WORD,
  parameter int          CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fetch_inst,
  input  logic             fetch_valid,
  input  logic             redirect,
  output logic [31:0]      id_inst,
  output logic [31:0]      ex_inst,
  output logic [31:0]      mem_inst,
  output logic             id_valid,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_count
);

  logic load_use;
  logic count_event;

  hazard_detect u_hazard (
    .id_inst  (id_inst),
    .id_valid (id_valid),
    .ex_inst  (ex_inst),
    .ex_valid (ex_valid),
    .load_use (load_use)
  );

  // A redirect during a stall is ignored, so it is only counted on a non-stall edge.
  always_comb begin
    stall       = load_use;
    count_event = load_use || redirect;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_inst   <= BUBBLE;
      ex_inst   <= BUBBLE;
      mem_inst  <= BUBBLE;
      id_valid  <= 1'b0;
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
    end else begin
      mem_inst  <= ex_inst;
      mem_valid <= ex_valid;
      if (stall) begin
        ex_inst  <= BUBBLE;
        ex_valid <= 1'b0;
      end else begin
        ex_inst  <= id_inst;
        ex_valid <= id_valid;
        if (redirect) begin
          id_inst  <= BUBBLE;
          id_valid <= 1'b0;
        end else begin
          id_inst  <= fetch_valid ? fetch_inst : BUBBLE;
          id_valid <= fetch_valid;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (count_event && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_pipe_tracker.sv
// Directed and randomized checks of inst_pipe_tracker against a stage-array reference model.
module tb_inst_pipe_tracker;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_inst;
  logic        fetch_valid;
  logic        redirect;
  logic [31:0] id_inst;
  logic [31:0] ex_inst;
  logic [31:0] mem_inst;
  logic        id_valid;
  logic        ex_valid;
  logic        mem_valid;
  logic        stall;
  logic [15:0] bubble_count;

  int errors;
  int checks;

  // Reference model: stage 0 = ID, 1 = EX, 2 = MEM.
  logic [31:0] ref_word  [3];
  logic        ref_valid [3];
  int          ref_count;

  inst_pipe_tracker #(.BUBBLE(32'h0), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_inst   (fetch_inst),
    .fetch_valid  (fetch_valid),
    .redirect     (redirect),
    .id_inst      (id_inst),
    .ex_inst      (ex_inst),
    .mem_inst     (mem_inst),
    .id_valid     (id_valid),
    .ex_valid     (ex_valid),
    .mem_valid    (mem_valid),
    .stall        (stall),
    .bubble_count (bubble_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Hazard rule straight from the decode-field definitions.
  function automatic logic ref_stall();
    logic [5:0] id_op, ex_op;
    logic       rd_rs, rd_rt;
    id_op = ref_word[0][31:26];
    ex_op = ref_word[1][31:26];
    rd_rs = ref_valid[0] && id_op != 6'b000010;
    rd_rt = ref_valid[0] && (id_op == 6'd0 || id_op == 6'b101011);
    return ref_valid[1] && ex_op == 6'b100011 && ref_word[1][20:16] != 5'd0 &&
           ((rd_rs && ref_word[0][25:21] == ref_word[1][20:16]) ||
            (rd_rt && ref_word[0][20:16] == ref_word[1][20:16]));
  endfunction

  task automatic model_edge(input logic r, input logic [31:0] fi, input logic fv, input logic rd);
    logic s;
    s = ref_stall();
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        ref_word[i]  = 32'h0;
        ref_valid[i] = 1'b0;
      end
      ref_count = 0;
    end else begin
      if ((s || rd) && ref_count < 65535) ref_count++;
      ref_word[2]  = ref_word[1];
      ref_valid[2] = ref_valid[1];
      if (s) begin
        ref_word[1]  = 32'h0;
        ref_valid[1] = 1'b0;
      end else begin
        ref_word[1]  = ref_word[0];
        ref_valid[1] = ref_valid[0];
        ref_word[0]  = (rd || !fv) ? 32'h0 : fi;
        ref_valid[0] = !rd && fv;
      end
    end
  endtask

  task automatic check_state();
    checkOutput("id_inst",   id_inst,   ref_word[0]);
    checkOutput("ex_inst",   ex_inst,   ref_word[1]);
    checkOutput("mem_inst",  mem_inst,  ref_word[2]);
    checkOutput("id_valid",  32'(id_valid),  32'(ref_valid[0]));
    checkOutput("ex_valid",  32'(ex_valid),  32'(ref_valid[1]));
    checkOutput("mem_valid", 32'(mem_valid), 32'(ref_valid[2]));
    checkOutput("bubble_count", 32'(bubble_count), 32'(ref_count));
  endtask

  // One cycle: drive at the falling edge, check stall, clock, check registered state.
  task automatic applyStimulus(input logic r, input logic [31:0] fi, input logic fv, input logic rd);
    rst         = r;
    fetch_inst  = fi;
    fetch_valid = fv;
    redirect    = rd;
    #1;
    checkOutput("stall", 32'(stall), 32'(ref_stall()));
    @(posedge clk);
    model_edge(r, fi, fv, rd);
    @(negedge clk);
    check_state();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs, rt, rdst;
    rs   = 5'($urandom_range(0, 3));
    rt   = 5'($urandom_range(0, 3));
    rdst = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0:       return {6'b000000, rs, rt, rdst, 5'd0, 6'b100011};
      1:       return {6'b100011, rs, rt, 16'h0004};
      2:       return {6'b101011, rs, rt, 16'h0008};
      3:       return {6'b001000, rs, rt, 16'h0001};
      4:       return {6'b000010, 26'h10};
      default: return {6'b000001, rs, 5'd0, 16'h0002};
    endcase
  endfunction

  localparam logic [31:0] ADDI = 32'h2008_0005;
  localparam logic [31:0] LW9  = 32'h8D09_0000;
  localparam logic [31:0] SUBU = 32'h0128_5023;
  localparam logic [31:0] LW0  = 32'h8D00_0000;
  localparam logic [31:0] SUBU0 = 32'h0008_5023;
  localparam logic [31:0] JMP  = 32'h0800_0010;
  localparam logic [31:0] BLTZ9 = 32'h0520_0004;

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 3; i++) begin
      ref_word[i]  = 32'h0;
      ref_valid[i] = 1'b0;
    end
    ref_count   = 0;
    rst         = 1'b1;
    fetch_inst  = 32'h0;
    fetch_valid = 1'b0;
    redirect    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_state();
    checkOutput("reset_stall", 32'(stall), 32'h0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checkOutput("idle_id", id_inst, 32'h0);
    checkOutput("idle_count", 32'(bubble_count), 32'h0);

    // Independent op latency: ID, EX, MEM on successive edges.
    applyStimulus(1'b0, ADDI, 1'b1, 1'b0);
    checkOutput("lat_id", id_inst, ADDI);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("lat_ex", ex_inst, ADDI);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("lat_mem", mem_inst, ADDI);

    // Load-use: one stall, bubble in EX, subu held in ID.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, LW9, 1'b1, 1'b0);
    applyStimulus(1'b0, SUBU, 1'b1, 1'b0);
    checkOutput("lu_stall", 32'(stall), 32'h1);
    applyStimulus(1'b0, ADDI, 1'b1, 1'b0);
    checkOutput("lu_ex_bubble", ex_inst, 32'h0);
    checkOutput("lu_ex_valid", 32'(ex_valid), 32'h0);
    checkOutput("lu_id_held", id_inst, SUBU);
    checkOutput("lu_count", 32'(bubble_count), 32'h1);
    checkOutput("lu_stall_done", 32'(stall), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    // Load to $0 never stalls.
    applyStimulus(1'b0, LW0, 1'b1, 1'b0);
    applyStimulus(1'b0, SUBU0, 1'b1, 1'b0);
    checkOutput("lw0_stall", 32'(stall), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    // Redirect flushes the delay-slot fetch and the jump moves on to EX.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, JMP, 1'b1, 1'b0);
    applyStimulus(1'b0, ADDI, 1'b1, 1'b1);
    checkOutput("rd_id", id_inst, 32'h0);
    checkOutput("rd_id_valid", 32'(id_valid), 32'h0);
    checkOutput("rd_ex", ex_inst, JMP);
    checkOutput("rd_count", 32'(bubble_count), 32'h1);

    // Redirect held across a stall: held first, flushed on the next edge.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, LW9, 1'b1, 1'b0);
    applyStimulus(1'b0, BLTZ9, 1'b1, 1'b0);
    applyStimulus(1'b0, ADDI, 1'b1, 1'b1);
    checkOutput("rs_id_held", id_inst, BLTZ9);
    applyStimulus(1'b0, ADDI, 1'b1, 1'b1);
    checkOutput("rs_id_flushed", 32'(id_valid), 32'h0);
    checkOutput("rs_count", 32'(bubble_count), 32'h2);

    // Reset during a stall.
    applyStimulus(1'b0, LW9, 1'b1, 1'b0);
    applyStimulus(1'b0, SUBU, 1'b1, 1'b0);
    applyStimulus(1'b1, ADDI, 1'b1, 1'b0);
    checkOutput("rst_id", id_inst, 32'h0);
    checkOutput("rst_ex", ex_inst, 32'h0);
    checkOutput("rst_count", 32'(bubble_count), 32'h0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), rand_inst(),
                    ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
